// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM write arbiter: default widths,
// requester ids and the one-entry slot record.
package ram_ctrl_pkg;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_ADDR_W = 1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic                  full;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/ram_write_arbiter_if.sv
// Bundle of the two requester handshakes plus the registered RAM write port.
interface ram_write_arbiter_if
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              Write_Enable;
  logic [ADDR_W-1:0] Write_Address;
  logic [DATA_W-1:0] Write_Data;
  logic              grant_id;
  logic              collision;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  Write_Enable, Write_Address, Write_Data, grant_id, collision
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output Write_Enable, Write_Address, Write_Data, grant_id, collision
  );

endinterface

// File: rtl/ram_req_slot.sv
// One-entry holding register for a single requester. Accepts whenever empty or
// being drained this cycle, so a granted slot can reload on the same edge.
module ram_req_slot
  import ram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [DEF_ADDR_W-1:0] addr,
  input  logic [DEF_DATA_W-1:0] data,
  input  logic                  grant,
  output logic                  ready,
  output slot_t                 slot
);

  // grant comes only from registered slot state, so ready has no path from valid
  assign ready = !slot.full || grant;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: payload is reset with the full bit; it is tiny and keeps the RAM port X-free.
      slot <= '0;
    end else if (valid && ready) begin
      slot <= '{full: 1'b1, addr: addr, data: data};
    end else if (grant) begin
      slot.full <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// Two-requester arbiter for the single RAM write port; round-robin by default,
// fixed priority to requester 0 when FIXED_PRIO_EN is defined.
module ram_write_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)(
  input logic                clk,
  input logic                reset,
  ram_write_arbiter_if.slave bus
);

  slot_t             slot0;
  slot_t             slot1;
  logic              ready0;
  logic              ready1;
  logic              grant;
  logic              sel;
  logic              grant0;
  logic              grant1;
  logic              both_full;
  logic              same_addr;
  logic              same_addr_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              id_q;
  logic              coll_q;

  ram_req_slot u_slot0 (
    .clk   (clk),
    .reset (reset),
    .valid (bus.req0_valid),
    .addr  (bus.req0_addr),
    .data  (bus.req0_data),
    .grant (grant0),
    .ready (ready0),
    .slot  (slot0)
  );

  ram_req_slot u_slot1 (
    .clk   (clk),
    .reset (reset),
    .valid (bus.req1_valid),
    .addr  (bus.req1_addr),
    .data  (bus.req1_data),
    .grant (grant1),
    .ready (ready1),
    .slot  (slot1)
  );

`ifdef FIXED_PRIO_EN
  // Requester 0 always wins a tie; requester 1 may starve in this build.
  always_comb begin
    // NOTE: defaults first so no path through always_comb leaves sel unassigned (no latch).
    grant = slot0.full || slot1.full;
    sel   = slot0.full ? REQ0 : REQ1;
  end
`else
  logic rr_ptr;

  always_comb begin
    grant = slot0.full || slot1.full;
    sel   = REQ0;
    if (slot0.full && slot1.full) begin
      sel = rr_ptr;
    end else if (slot1.full) begin
      sel = REQ1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= REQ0;
    end else if (grant) begin
      rr_ptr <= ~sel;
    end
  end
`endif

  assign grant0    = grant && (sel == REQ0);
  assign grant1    = grant && (sel == REQ1);
  assign both_full = slot0.full && slot1.full;
  assign same_addr = both_full && (slot0.addr == slot1.addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      id_q        <= REQ0;
      coll_q      <= 1'b0;
      same_addr_q <= 1'b0;
    end else begin
      we_q <= grant;
      if (grant) begin
        addr_q <= (sel == REQ1) ? slot1.addr : slot0.addr;
        data_q <= (sel == REQ1) ? slot1.data : slot0.data;
        id_q   <= sel;
      end
      // flag only the first edge of a same-address pairing, not every reload of it
      coll_q      <= same_addr && !same_addr_q;
      same_addr_q <= same_addr;
    end
  end

  assign bus.req0_ready    = ready0;
  assign bus.req1_ready    = ready1;
  assign bus.Write_Enable  = we_q;
  assign bus.Write_Address = addr_q;
  assign bus.Write_Data    = data_q;
  assign bus.grant_id      = id_q;
  assign bus.collision     = coll_q;

endmodule

// File: doc/ram_write_arbiter.md
Name: ram_write_arbiter

Overview:
Shares the single write port of the 2-entry x 2-bit register RAM between two independent requesters. Each requester hands off writes through a valid/ready handshake into its own one-entry slot. The arbiter selects one pending slot per cycle and drives registered Write_Enable, Write_Address and Write_Data into the RAM. The RAM read ports are untouched and remain wired directly to consumers.

Parameters:
DATA_W, 2, width of write data (matches RAM word width)
ADDR_W, 1, width of write address (RAM depth = 2**ADDR_W)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a write to hand off
req0_ready  out  1  requester 0 slot can accept this cycle
req0_addr  in  ADDR_W  requester 0 write address
req0_data  in  DATA_W  requester 0 write data
req1_valid  in  1  requester 1 has a write to hand off
req1_ready  out  1  requester 1 slot can accept this cycle
req1_addr  in  ADDR_W  requester 1 write address
req1_data  in  DATA_W  requester 1 write data
Write_Enable  out  1  to RAM; registered
Write_Address  out  ADDR_W  to RAM; registered
Write_Data  out  DATA_W  to RAM; registered
grant_id  out  1  requester whose write is on the RAM port this cycle
collision  out  1  one-cycle pulse when both slots hold the same address

Behaviour:
- Reset (async, any time): both slots empty; rr_ptr=0; Write_Enable=0, Write_Address=0, Write_Data=0, grant_id=0, collision=0. Pending writes are dropped, not replayed.
- Handshake: transfer on the rising edge when reqN_valid && reqN_ready. Payload must be stable while valid && !ready. Valid must not depend on ready.
- Slot N is full from the accepting edge until the edge where it is granted.
- sel (combinational, registers only):
  - Neither slot full: no grant.
  - One slot full: that slot is granted.
  - Both slots full: the slot indexed by rr_ptr is granted.
- reqN_ready = !fullN || (grant && sel==N). Ready depends only on registers. There is no valid->ready combinational path.
- Throughput: 1 write/cycle per requester when alone; aggregate 1 write/cycle.
- Grant edge:
  - Write_Enable<=1; Write_Address/Write_Data<=slot payload; grant_id<=sel.
  - Granted slot clears, or reloads if the same edge accepts a new transfer.
  - rr_ptr<=~sel.
- No grant: Write_Enable<=0; address, data and grant_id hold their values.
- Latency: accepted at edge k, granted at edge k+1 (if uncontended), visible on the RAM port during cycle k+1, written into the RAM at edge k+2. Under contention, at most one extra cycle.
- Same-address contention: both writes are issued in grant order, so the later grant wins in the RAM. collision<=1 for one cycle on the first grant edge where both slots are full with equal addresses.
- Simultaneous accept on both requesters: both slots load on the same edge; the rr_ptr holder is granted first.

Optional Feature:
FIXED_PRIO_EN
- Defined: requester 0 always wins when both slots are full. rr_ptr is not implemented and grant_id follows the fixed priority. Requester 1 may starve, which is documented as acceptable for that build.
- Undefined: round-robin as above. Starvation-free, with a bound of 1 cycle wait under contention.

Decomposition:
- Package ram_ctrl_pkg holds:
  - DATA_W/ADDR_W defaults
  - REQ0=1'b0 and REQ1=1'b1 ids
  - the slot record layout {full, addr, data}
- Sub-module ram_req_slot: one-entry holding register with load/clear/ready logic, instantiated twice.
- Arbitration and output registers stay in the top level.

Test Plan:
- Reset released with no requests -> Write_Enable=0, req0_ready=req1_ready=1 for 5 cycles. Assert reset mid-burst -> all outputs return to 0 immediately, without waiting for an edge.
- req0 writes addr0=01 alone -> Write_Enable=1, Write_Address=0, Write_Data=01, grant_id=0 in the cycle after accept. RAM Read_Data_1 (addr0)=01 one edge later.
- req0 (addr0=01) and req1 (addr1=11) are valid on the same edge -> grants in the order req0 then req1 on consecutive cycles. RAM holds addr0=01, addr1=11.
- Both requesters continuously valid for 6 cycles -> grant_id alternates 0,1,0,1,... with no idle cycle and each ready toggling as its slot is drained.
- req0 addr1=10 and req1 addr1=11 on the same edge -> collision pulses once. Final RAM addr1=11 (round-robin), or 11 with FIXED_PRIO_EN since req1 is issued second.
- FIXED_PRIO_EN, both continuously valid -> grant_id stays 0 and req1_ready stays 0 while req0 is valid.
